// File: rtl/apb4_cmd_master.sv
// APB4 requester: queued read/write commands run as APB4 transfers with
// wait-state counting, optional timeout abort and one response per command.
module apb4_cmd_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CMD_DEPTH  = 4,
    parameter int unsigned TIMEOUT    = 5000,
    parameter int unsigned WAIT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr,
    input  logic [DATA_WIDTH-1:0]         cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]       cmd_strb,
    input  logic [2:0]                    cmd_prot,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_err,
    output logic [WAIT_W-1:0]             rsp_wait,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [2:0]                    PPROT,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    output logic [DATA_WIDTH/8-1:0]       PSTRB,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR,
    output logic                          busy,
    output logic [$clog2(CMD_DEPTH):0]    cmd_level
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0]     strb;
        logic [2:0]            prot;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    cmd_t                  mem_q [CMD_DEPTH];
    cmd_t                  mem_d [CMD_DEPTH];
    cmd_t                  head;
    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  rdy_en_q, rdy_en_d;
    logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d, wait_inc;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_err_q, rsp_err_d;
    logic [WAIT_W-1:0]     rsp_wait_q, rsp_wait_d;
    logic                  full, push, pop;

    // cmd_ready depends only on registered state, never on this cycle's pop
    assign full      = (level_q == LVL_W'(CMD_DEPTH));
    assign cmd_ready = rdy_en_q && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (level_q != '0) && (!rsp_valid_q || rsp_ready);
    assign head      = mem_q[rd_ptr_q];
    assign wait_inc  = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;

    always_comb begin
        mem_d       = mem_q;
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rdy_en_d    = 1'b1;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pprot_d     = pprot_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_wait_d  = rsp_wait_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                                strb: cmd_strb, prot: cmd_prot};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d    = SETUP;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    pwrite_d   = head.write;
                    paddr_d    = head.addr;
                    pwdata_d   = head.wdata;
                    pstrb_d    = head.write ? head.strb : '0;
                    pprot_d    = head.prot;
                    wait_cnt_d = '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = {1'b0, PSLVERR};
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_wait_d  = wait_cnt_q;
                end else begin
                    wait_cnt_d = wait_inc;
                    if ((TIMEOUT != 0) && (32'(wait_inc) == TIMEOUT)) begin
                        state_d     = IDLE;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 2'b10;
                        rsp_rdata_d = '0;
                        rsp_wait_d  = wait_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rdy_en_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pprot_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= '0;
            rsp_wait_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rdy_en_q    <= rdy_en_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pprot_q     <= pprot_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_wait_q  <= rsp_wait_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PPROT     = pprot_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_wait  = rsp_wait_q;
    assign cmd_level = level_q;
    assign busy      = (level_q != '0) || (state_q != IDLE) || rsp_valid_q;
endmodule
